// File: rtl/coin_credit_if.sv
// Coin-acceptor handshake bundle: coin/cancel/vend requests in, credit and change reporting out.
interface coin_credit_if #(
  parameter int unsigned CREDIT_W = 7
);
  logic                coin_valid;
  logic [1:0]          coin_value;
  logic                cancel_button;
  logic                vend_req;
  logic                money;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;

  modport master (
    output coin_valid, coin_value, cancel_button, vend_req,
    input  money, credit, coin_reject, change_valid, change_amount
  );

  modport slave (
    input  coin_valid, coin_value, cancel_button, vend_req,
    output money, credit, coin_reject, change_valid, change_amount
  );
endinterface

// File: rtl/coin_credit.sv
// Coin credit accumulator for the vending path: collects coins, holds money during dispense,
// then pays out change or a full refund on cancel.
module coin_credit #(
  parameter int unsigned PRICE           = 30,
  parameter int unsigned CREDIT_MAX      = 60,
  parameter int unsigned CREDIT_W        = 7,
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  coin_credit_if.slave bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCollect = 3'd1;
  localparam logic [2:0] StReady   = 3'd2;
  localparam logic [2:0] StVend    = 3'd3;
  localparam logic [2:0] StChange  = 3'd4;

  localparam int unsigned CntW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CntW-1:0]     CntLoad = CntW'(DISPENSE_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] PriceW  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MaxW    = (CREDIT_W + 1)'(CREDIT_MAX);

  logic [2:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                money_q, money_d;
  logic                coin_reject_q, coin_reject_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;

  logic [CREDIT_W-1:0] coin_units;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;

  always_comb begin
    coin_units = '0;
    unique case (bus.coin_value)
      2'd0: coin_units = CREDIT_W'(1);
      2'd1: coin_units = CREDIT_W'(2);
      2'd2: coin_units = CREDIT_W'(5);
      2'd3: coin_units = CREDIT_W'(10);
    endcase
  end

  // One extra bit so an over-limit sum cannot wrap back under CREDIT_MAX.
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_units};
  assign coin_fits = (coin_sum <= MaxW);

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    cnt_d           = cnt_q;
    coin_reject_d   = 1'b0;
    change_valid_d  = 1'b0;
    change_amount_d = change_amount_q;

    case (state_q)
      StIdle, StCollect, StReady: begin
        if (bus.cancel_button && (state_q != StIdle)) begin
          state_d         = StChange;
          change_amount_d = credit_q;
          change_valid_d  = (credit_q != '0);
          credit_d        = '0;
          coin_reject_d   = bus.coin_valid;
        end else if (bus.vend_req && (state_q == StReady)) begin
          state_d       = StVend;
          cnt_d         = CntLoad;
          coin_reject_d = bus.coin_valid;
        end else begin
          if (bus.coin_valid) begin
            if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
            else coin_reject_d = 1'b1;
          end
          // Next state follows the post-update credit so money rises one cycle after the coin.
          if (credit_d >= PriceW)   state_d = StReady;
          else if (credit_d != '0) state_d = StCollect;
          else                      state_d = StIdle;
        end
      end

      StVend: begin
        coin_reject_d = bus.coin_valid;
        if (cnt_q == '0) begin
          state_d         = StChange;
          change_amount_d = credit_q - PriceW;
          change_valid_d  = (credit_q != PriceW);
          credit_d        = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StChange: begin
        coin_reject_d = bus.coin_valid;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase

    money_d = (state_d == StReady) || (state_d == StVend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      credit_q        <= '0;
      cnt_q           <= '0;
      money_q         <= 1'b0;
      coin_reject_q   <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      cnt_q           <= cnt_d;
      money_q         <= money_d;
      coin_reject_q   <= coin_reject_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
    end
  end

  assign bus.money         = money_q;
  assign bus.credit        = credit_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amount = change_amount_q;

endmodule
